// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB controller: register map, bit positions,
// slave sequencing states and the power-on baud divisor.
package uart_pkg;

    localparam int unsigned RESET_DIVSR = 650;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;
    localparam logic [3:0] UART_DIVSR  = 4'hC;

    localparam int STAT_RX_EMPTY     = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_OVERRUN      = 4;
    localparam int STAT_RX_UNDERFLOW = 5;
    localparam int STAT_TX_OVERFLOW  = 6;

    localparam int CTRL_RX_EN          = 0;
    localparam int CTRL_TX_EN          = 1;
    localparam int CTRL_IE_RX_NONEMPTY = 2;
    localparam int CTRL_IE_TX_EMPTY    = 3;
    localparam int CTRL_IE_ERR         = 4;
    localparam int CTRL_W              = 5;

    localparam logic [CTRL_W-1:0] CTRL_RESET = 5'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/uart_apb_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and the UART controller (slave).
interface uart_apb_ctrl_if;
    // psel with penable=0 is the setup phase; the slave finishes the transfer by
    // holding pready high for one cycle, and prdata/pslverr are meaningful only then.
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_fsm.sv
// Sequences every APB transfer through setup, one wait state and a completion cycle.
module apb_slave_fsm
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       psel,
    input  logic       penable,
    output logic       pready,
    output logic       in_wait,
    output apb_state_e state
);

    apb_state_e state_q;
    logic       pready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q <= 1'b0;
                    if (psel && !penable) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_q  <= ST_DONE;
                    pready_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    pready_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pready  = pready_q;
    assign in_wait = (state_q == ST_WAIT);
    assign state   = state_q;

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB3 register front end for the UART: divisor, control, sticky error flags,
// and single-cycle pop/push strobes toward the RX and TX FIFOs.
module uart_apb_ctrl #(
    parameter int          DIVSR_W     = 11,
    parameter int          DATA_W      = 8,
    parameter int unsigned RESET_DIVSR = uart_pkg::RESET_DIVSR
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_apb_ctrl_if.slave         apb,
    output logic [DIVSR_W-1:0]     divsr,
    input  logic [DATA_W-1:0]      rx_dataOut,
    input  logic                   rx_empty,
    input  logic                   rx_full,
    input  logic                   rx_doneTick,
    output logic                   rx_readEn,
    output logic [DATA_W-1:0]      tx_dataIn,
    output logic                   tx_writeEn,
    input  logic                   tx_full,
    input  logic                   tx_empty,
    output logic                   irq,
    output uart_pkg::apb_state_e   dbg_state
);

    localparam int CW = uart_pkg::CTRL_W;

    logic                 in_wait;
    logic [3:0]           reg_sel;
    logic [31:0]          status_word;
    logic                 unused_bits;

    logic [31:0]          prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic [DIVSR_W-1:0]   divsr_q, divsr_d;
    logic [CW-1:0]        ctrl_q, ctrl_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_underflow_q, rx_underflow_d;
    logic                 tx_overflow_q, tx_overflow_d;
    logic                 rx_read_en_q, rx_read_en_d;
    logic                 tx_write_en_q, tx_write_en_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 irq_q, irq_d;

    apb_slave_fsm u_fsm (
        .clk     (clk),
        .reset   (reset),
        .psel    (apb.psel),
        .penable (apb.penable),
        .pready  (apb.pready),
        .in_wait (in_wait),
        .state   (dbg_state)
    );

    assign reg_sel     = {apb.paddr[3:2], 2'b00};
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

    always_comb begin
        status_word = '0;
        status_word[uart_pkg::STAT_RX_EMPTY]     = rx_empty;
        status_word[uart_pkg::STAT_RX_FULL]      = rx_full;
        status_word[uart_pkg::STAT_TX_EMPTY]     = tx_empty;
        status_word[uart_pkg::STAT_TX_FULL]      = tx_full;
        status_word[uart_pkg::STAT_OVERRUN]      = overrun_q;
        status_word[uart_pkg::STAT_RX_UNDERFLOW] = rx_underflow_q;
        status_word[uart_pkg::STAT_TX_OVERFLOW]  = tx_overflow_q;
    end

    // Every side effect is decided in WAIT so that its registered result lands in DONE.
    always_comb begin
        prdata_d       = '0;
        pslverr_d      = 1'b0;
        rx_read_en_d   = 1'b0;
        tx_write_en_d  = 1'b0;
        tx_data_d      = tx_data_q;
        divsr_d        = divsr_q;
        ctrl_d         = ctrl_q;
        overrun_d      = overrun_q;
        rx_underflow_d = rx_underflow_q;
        tx_overflow_d  = tx_overflow_q;

        if (in_wait) begin
            case (reg_sel)
                uart_pkg::UART_DATA: begin
                    if (apb.pwrite) begin
                        if (tx_full || !ctrl_q[uart_pkg::CTRL_TX_EN]) begin
                            pslverr_d     = 1'b1;
                            tx_overflow_d = tx_overflow_q | tx_full;
                        end else begin
                            tx_write_en_d = 1'b1;
                            tx_data_d     = apb.pwdata[DATA_W-1:0];
                        end
                    end else begin
                        if (rx_empty || !ctrl_q[uart_pkg::CTRL_RX_EN]) begin
                            pslverr_d      = 1'b1;
                            rx_underflow_d = rx_underflow_q | rx_empty;
                        end else begin
                            rx_read_en_d = 1'b1;
                            prdata_d     = 32'(rx_dataOut);
                        end
                    end
                end
                uart_pkg::UART_STATUS: begin
                    if (apb.pwrite) begin
                        overrun_d      = overrun_q      & ~apb.pwdata[uart_pkg::STAT_OVERRUN];
                        rx_underflow_d = rx_underflow_q & ~apb.pwdata[uart_pkg::STAT_RX_UNDERFLOW];
                        tx_overflow_d  = tx_overflow_q  & ~apb.pwdata[uart_pkg::STAT_TX_OVERFLOW];
                    end else begin
                        prdata_d = status_word;
                    end
                end
                uart_pkg::UART_CTRL: begin
                    if (apb.pwrite) ctrl_d = apb.pwdata[CW-1:0];
                    else            prdata_d = 32'(ctrl_q);
                end
                uart_pkg::UART_DIVSR: begin
                    if (apb.pwrite) begin
                        if (apb.pwdata[DIVSR_W-1:0] == '0) pslverr_d = 1'b1;
                        else                               divsr_d   = apb.pwdata[DIVSR_W-1:0];
                    end else begin
                        prdata_d = 32'(divsr_q);
                    end
                end
                default: ;
            endcase
        end

        // Evaluated after the W1C clear so a fresh overrun survives a same-cycle clear.
        if (ctrl_q[uart_pkg::CTRL_RX_EN] && rx_doneTick && rx_full) overrun_d = 1'b1;

        irq_d = (ctrl_q[uart_pkg::CTRL_IE_RX_NONEMPTY] & ~rx_empty)
              | (ctrl_q[uart_pkg::CTRL_IE_TX_EMPTY]    & tx_empty)
              | (ctrl_q[uart_pkg::CTRL_IE_ERR] & (overrun_q | rx_underflow_q | tx_overflow_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prdata_q       <= '0;
            pslverr_q      <= 1'b0;
            divsr_q        <= DIVSR_W'(RESET_DIVSR);
            ctrl_q         <= uart_pkg::CTRL_RESET;
            overrun_q      <= 1'b0;
            rx_underflow_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
            rx_read_en_q   <= 1'b0;
            tx_write_en_q  <= 1'b0;
            tx_data_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            prdata_q       <= prdata_d;
            pslverr_q      <= pslverr_d;
            divsr_q        <= divsr_d;
            ctrl_q         <= ctrl_d;
            overrun_q      <= overrun_d;
            rx_underflow_q <= rx_underflow_d;
            tx_overflow_q  <= tx_overflow_d;
            rx_read_en_q   <= rx_read_en_d;
            tx_write_en_q  <= tx_write_en_d;
            tx_data_q      <= tx_data_d;
            irq_q          <= irq_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign divsr       = divsr_q;
    assign rx_readEn   = rx_read_en_q;
    assign tx_writeEn  = tx_write_en_q;
    assign tx_dataIn   = tx_data_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed bench for uart_apb_ctrl with an RX FIFO model and byte scoreboards.
module tb_uart_apb_ctrl;
    import uart_pkg::*;

    localparam int DIVSR_W = 11;
    localparam int DATA_W  = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_apb_ctrl_if apb();

    logic [DIVSR_W-1:0] divsr;
    logic [DATA_W-1:0]  rx_dataOut;
    logic               rx_empty, rx_full, rx_doneTick, rx_readEn;
    logic [DATA_W-1:0]  tx_dataIn;
    logic               tx_writeEn, tx_full, tx_empty, irq;
    apb_state_e         dbg_state;

    uart_apb_ctrl #(.DIVSR_W(DIVSR_W), .DATA_W(DATA_W), .RESET_DIVSR(650)) dut (
        .clk         (clk),
        .reset       (reset),
        .apb         (apb),
        .divsr       (divsr),
        .rx_dataOut  (rx_dataOut),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_doneTick (rx_doneTick),
        .rx_readEn   (rx_readEn),
        .tx_dataIn   (tx_dataIn),
        .tx_writeEn  (tx_writeEn),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .irq         (irq),
        .dbg_state   (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard queues and RX FIFO model
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_tx_q[$];
    logic [DATA_W-1:0] rx_model[$];
    logic              rx_full_force = 1'b0;

    // pulse monitor
    int                rx_pulse_cnt = 0;
    int                tx_pulse_cnt = 0;
    logic [DATA_W-1:0] tx_last_data = '0;
    always @(posedge clk) begin
        if (rx_readEn) rx_pulse_cnt <= rx_pulse_cnt + 1;
        if (tx_writeEn) begin
            tx_pulse_cnt <= tx_pulse_cnt + 1;
            tx_last_data <= tx_dataIn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_refresh();
        rx_empty   = (rx_model.size() == 0);
        rx_full    = rx_full_force || (rx_model.size() >= 4);
        rx_dataOut = rx_empty ? '0 : rx_model[0];
    endtask

    task automatic rx_push(input logic [DATA_W-1:0] b);
        rx_model.push_back(b);
        exp_q.push_back(b);
        rx_refresh();
    endtask

    // driver: one full APB transfer, returns one cycle after DONE
    task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                            input bit tick_in_wait,
                            output logic [31:0] rdata, output logic err,
                            output logic rpop, output logic tpush);
        int n;
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        rx_doneTick = tick_in_wait;
        check("pready_in_wait", {31'd0, apb.pready}, 32'd0);
        n = 0;
        do begin
            @(posedge clk); #1;
            rx_doneTick = 1'b0;
            n++;
        end while (!apb.pready && n < 8);
        check("pready_done", {31'd0, apb.pready}, 32'd1);
        rdata = apb.prdata;
        err   = apb.pslverr;
        rpop  = rx_readEn;
        tpush = tx_writeEn;
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(posedge clk); #1;
        if (rpop && rx_model.size() != 0) begin
            void'(rx_model.pop_front());
            rx_refresh();
        end
        check("prdata_idle", apb.prdata, 32'd0);
    endtask

    task automatic reg_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic er, rp, tp;
        apb_xfer(1'b0, addr, 32'd0, 1'b0, rd, er, rp, tp);
        check(tag, rd, exp);
        check({tag, "_err"}, {31'd0, er}, 32'd0);
    endtask

    task automatic reg_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                             input bit exp_err, input bit tick);
        logic [31:0] rd; logic er, rp, tp;
        apb_xfer(1'b1, addr, data, tick, rd, er, rp, tp);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic data_read(input string tag, input bit expect_ok);
        logic [31:0] rd; logic er, rp, tp;
        logic [DATA_W-1:0] exp;
        int cnt0;
        cnt0 = rx_pulse_cnt;
        apb_xfer(1'b0, UART_DATA, 32'd0, 1'b0, rd, er, rp, tp);
        if (expect_ok) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check({tag, "_data"}, rd, 32'(exp));
            check({tag, "_err"}, {31'd0, er}, 32'd0);
            check({tag, "_pops"}, rx_pulse_cnt - cnt0, 32'd1);
        end else begin
            check({tag, "_data"}, rd, 32'd0);
            check({tag, "_err"}, {31'd0, er}, 32'd1);
            check({tag, "_pops"}, rx_pulse_cnt - cnt0, 32'd0);
        end
    endtask

    task automatic data_write(input string tag, input logic [DATA_W-1:0] b, input bit expect_ok);
        logic [31:0] rd; logic er, rp, tp;
        int cnt0;
        cnt0 = tx_pulse_cnt;
        if (expect_ok) exp_tx_q.push_back(b);
        apb_xfer(1'b1, UART_DATA, {24'hABCDE0, b}, 1'b0, rd, er, rp, tp);
        check({tag, "_err"}, {31'd0, er}, {31'd0, !expect_ok});
        check({tag, "_pushes"}, tx_pulse_cnt - cnt0, expect_ok ? 32'd1 : 32'd0);
        if (expect_ok)
            check({tag, "_byte"}, 32'(tx_last_data),
                  32'((exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 'x));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prdata"},  apb.prdata, 32'd0);
        check({tag, "_pready"},  {31'd0, apb.pready}, 32'd0);
        check({tag, "_pslverr"}, {31'd0, apb.pslverr}, 32'd0);
        check({tag, "_divsr"},   32'(divsr), 32'd650);
        check({tag, "_rxrd"},    {31'd0, rx_readEn}, 32'd0);
        check({tag, "_txwr"},    {31'd0, tx_writeEn}, 32'd0);
        check({tag, "_txdata"},  32'(tx_dataIn), 32'd0);
        check({tag, "_irq"},     {31'd0, irq}, 32'd0);
        check({tag, "_state"},   32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int cnt0;
        reset = 1'b1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        rx_doneTick = 1'b0; tx_full = 1'b0; tx_empty = 1'b1;
        rx_refresh();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        reg_read("rd_divsr_rst", UART_DIVSR, 32'd650);
        reg_read("rd_ctrl_rst", UART_CTRL, 32'h3);
        reg_read("rd_status_rst", UART_STATUS, 32'h05);

        reg_write("wr_divsr_325", UART_DIVSR, 32'd325, 1'b0, 1'b0);
        check("divsr_325", 32'(divsr), 32'd325);
        reg_write("wr_divsr_0", UART_DIVSR, 32'd0, 1'b1, 1'b0);
        check("divsr_kept", 32'(divsr), 32'd325);
        reg_read("rd_divsr_325", UART_DIVSR, 32'd325);

        // RX path
        rx_push(8'h55);
        rx_push(8'hF0);
        data_read("rx_55", 1'b1);
        data_read("rx_f0", 1'b1);
        data_read("rx_under", 1'b0);
        reg_read("status_under", UART_STATUS, 32'h25);

        // TX path
        data_write("tx_a5", 8'hA5, 1'b1);
        tx_full = 1'b1; tx_empty = 1'b0;
        data_write("tx_full", 8'h11, 1'b0);
        reg_read("status_ovf", UART_STATUS, 32'h69);
        reg_write("w1c_40", UART_STATUS, 32'h40, 1'b0, 1'b0);
        reg_read("status_ovf_clr", UART_STATUS, 32'h29);
        reg_write("w1c_20", UART_STATUS, 32'h20, 1'b0, 1'b0);
        reg_read("status_under_clr", UART_STATUS, 32'h09);
        tx_full = 1'b0; tx_empty = 1'b1;

        // overrun and irq
        reg_write("wr_ctrl_13", UART_CTRL, 32'h13, 1'b0, 1'b0);
        check("irq_quiet", {31'd0, irq}, 32'd0);
        rx_full_force = 1'b1; rx_refresh();
        @(posedge clk); #1; rx_doneTick = 1'b1;
        @(posedge clk); #1; rx_doneTick = 1'b0;
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        reg_read("status_ovr", UART_STATUS, 32'h17);
        reg_write("w1c_10_race", UART_STATUS, 32'h10, 1'b0, 1'b1);
        reg_read("status_ovr_kept", UART_STATUS, 32'h17);
        check("irq_kept", {31'd0, irq}, 32'd1);
        rx_full_force = 1'b0; rx_refresh();
        reg_write("w1c_10", UART_STATUS, 32'h10, 1'b0, 1'b0);
        reg_read("status_ovr_clr", UART_STATUS, 32'h05);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // receiver strobes ignored and DATA reads refused with rx_en=0
        reg_write("wr_ctrl_12", UART_CTRL, 32'h12, 1'b0, 1'b0);
        rx_full_force = 1'b1; rx_refresh();
        @(posedge clk); #1; rx_doneTick = 1'b1;
        @(posedge clk); #1; rx_doneTick = 1'b0;
        reg_read("status_rx_dis", UART_STATUS, 32'h07);
        rx_full_force = 1'b0; rx_refresh();
        rx_push(8'h3C);
        data_read("rx_dis", 1'b0);
        reg_write("wr_ctrl_13b", UART_CTRL, 32'h13, 1'b0, 1'b0);
        data_read("rx_3c", 1'b1);

        // reset during WAIT of a DATA read
        rx_push(8'h77);
        cnt0 = rx_pulse_cnt;
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = UART_DATA;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        check("rst_mid_wait", 32'(dbg_state), 32'(ST_WAIT));
        #1 reset = 1'b1;
        #1;
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        check("rst_mid_pops", rx_pulse_cnt - cnt0, 32'd0);
        reset = 1'b0;
        reg_read("status_after_rst", UART_STATUS, 32'h04);
        data_read("rx_77", 1'b1);
        reg_read("status_final", UART_STATUS, 32'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_apb_ctrl.md
# uart_apb_ctrl

APB3 slave that configures and sequences the UART datapath: it owns the baud divisor, moves bytes between the APB bus and the TX/RX FIFOs, and reports status, errors and interrupts. It sits between the APB interconnect and the `baud_gen`, `receiver`/`fifo` and transmitter/`fifo` instances. It holds no byte storage of its own; all data buffering stays in the FIFOs.

## Interface
- `DIVSR_W`, default 11: baud divisor width.
- `DATA_W`, default 8: UART byte width.
- `RESET_DIVSR`, default 650: divisor value after reset.
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high.
- `psel`, `penable`, `pwrite`  in  1 each: APB3 control.
- `paddr`  in  4: byte address; bits [1:0] are ignored.
- `pwdata`  in  32: write data.
- `prdata`  out  32: read data.
- `pready`  out  1: transfer complete.
- `pslverr`  out  1: transfer error.
- `divsr`  out  DIVSR_W: to `baud_gen`.
- `rx_dataOut`  in  DATA_W: RX FIFO head. First-word-fall-through, valid while `!rx_empty`.
- `rx_empty`, `rx_full`  in  1: RX FIFO flags.
- `rx_doneTick`  in  1: receiver byte-complete strobe.
- `rx_readEn`  out  1: RX FIFO pop.
- `tx_dataIn`  out  DATA_W: TX FIFO write data.
- `tx_writeEn`  out  1: TX FIFO push.
- `tx_full`, `tx_empty`  in  1: TX FIFO flags.
- `irq`  out  1: level interrupt.

## Operation
- Register map (word offsets):
  - 0x0 DATA. Read pops RX; write pushes TX using `pwdata[DATA_W-1:0]`.
  - 0x4 STATUS. Read: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 overrun, bit5 rx_underflow, bit6 tx_overflow. Write 1 to bits 4–6 clears them (W1C).
  - 0x8 CTRL, RW. bit0 rx_en, bit1 tx_en, bit2 ie_rx_nonempty, bit3 ie_tx_empty, bit4 ie_err. Reset value 0x3.
  - 0xC DIVSR, RW, bits [DIVSR_W-1:0]. Write of 0 is ignored and sets `pslverr`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT on `psel & !penable`.
  - WAIT → DONE unconditionally. The side effect is issued in WAIT: pop, push, or register update, and read data is captured in this state.
  - DONE drives `pready=1`. DONE → IDLE.
- DATA read with `rx_empty`: no pop; `prdata=0`; `pslverr=1`; rx_underflow set.
- DATA read with rx_en=0: no pop; `prdata=0`; `pslverr=1`.
- DATA write with `tx_full` or tx_en=0: no push; `pslverr=1`; tx_overflow set only in the `tx_full` case.
- Overrun: `rx_doneTick & rx_full` sets overrun. Receiver strobes are ignored while rx_en=0.
- Unmapped offset: none exist within 4 bits.
- `irq = (ie_rx_nonempty & !rx_empty) | (ie_tx_empty & tx_empty) | (ie_err & |{overrun, rx_underflow, tx_overflow})`, registered.
- Simultaneous W1C clear and a new set of the same flag: set wins.
- Reset mid-transfer: the FSM returns to IDLE with no pop or push issued. A pending transfer is abandoned, and the master must restart it.

## Timing
- Reset values: `prdata=0`, `pready=0`, `pslverr=0`, `divsr=RESET_DIVSR`, `rx_readEn=0`, `tx_writeEn=0`, `tx_dataIn=0`, `irq=0`, all sticky flags 0.
- Every transfer takes one wait state: setup, WAIT (`pready=0`), DONE (`pready=1`). Total 3 cycles.
- `rx_readEn` and `tx_writeEn` are one-cycle registered pulses asserted in the cycle after WAIT is entered. At most one pulse per transfer.
- `prdata` and `pslverr` are valid only while `pready=1`. `prdata` is 0 otherwise.
- A `divsr` update is visible the cycle after WAIT.
- `irq` lags its sources by 1 cycle.
- Back-to-back transfers: the next setup phase may start the cycle after DONE.

## Structure
- Shared package `uart_pkg` holds:
  - Register offsets: `UART_DATA`, `UART_STATUS`, `UART_CTRL`, `UART_DIVSR`.
  - STATUS and CTRL bit indices.
  - The FSM state enum.
  - `RESET_DIVSR`.
- Natural sub-module: `apb_slave_fsm`, covering the IDLE/WAIT/DONE sequencing and `pready`. Register decode and flags stay in the top level.

## Test plan
- Reset: all outputs at reset values; read DIVSR → 650; read CTRL → 0x3; read STATUS → 0x05 (bit0 rx_empty | bit2 tx_empty).
- Write DIVSR=325 → `divsr=325` next cycle, `pslverr=0`. Write DIVSR=0 → `pslverr=1`, `divsr` unchanged.
- RX path: model pushes 0x55 then 0xF0 → two DATA reads return 0x55 then 0xF0, each with a single `rx_readEn` pulse. A third read → `pslverr=1`, `prdata=0`, STATUS bit5 set.
- TX path: write 0xA5 → one `tx_writeEn` pulse with `tx_dataIn=0xA5`. With `tx_full=1`, write → no pulse, `pslverr=1`, STATUS bit6 set. W1C 0x40 → bit6 clears.
- Overrun and irq: `rx_full=1` plus an `rx_doneTick` pulse, with CTRL=0x13 → STATUS bit4 set and `irq=1` one cycle later. W1C 0x10 issued in the same cycle as a new `rx_doneTick` → bit4 stays 1.
- Assert `reset` during WAIT of a DATA read → no `rx_readEn`, FSM in IDLE, all outputs at reset values.
